// File: rtl/uart_loader_ctrl_pkg.sv
// Shared definitions for the UART loader command sequencer:
// command byte values, one-hot state encoding and a width helper.
package uart_loader_ctrl_pkg;

    // Command bytes recognised while idle
    localparam logic [7:0] CMD_LOAD  = 8'h4C;  // 'L'
    localparam logic [7:0] CMD_RUN   = 8'h52;  // 'R'
    localparam logic [7:0] CMD_STEP  = 8'h53;  // 'S'
    localparam logic [7:0] CMD_HALT  = 8'h48;  // 'H'
    localparam logic [7:0] CMD_RESET = 8'h58;  // 'X'

    // One-hot sequencer states
    typedef enum logic [3:0] {
        ST_IDLE     = 4'b0001,
        ST_GET_CNT  = 4'b0010,
        ST_GET_WORD = 4'b0100,
        ST_WRITE    = 4'b1000
    } state_t;

    // Bits needed to hold values 0..value-1, never less than 1
    function automatic int unsigned clog2_min1(input int unsigned value);
        int unsigned w;
        w = 1;
        while ((64'(1) << w) < 64'(value)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/uart_loader_ctrl.sv
// Command sequencer between the UART receiver and the MIPS core.
// Decodes single-byte commands, assembles instruction words from a LOAD
// stream and writes them to instruction memory, and drives run/step/reset.
//
// Ports:
//   clk, i_rst_n       clock, asynchronous active-low reset
//   i_rx_data/i_rx_done received byte and its one-cycle strobe
//   i_cpu_halted       core has executed HALT (level)
//   o_imem_we/addr/wdata  instruction memory write port
//   o_cpu_run/step/rst free-run level, single-step pulse, core reset pulse
//   o_busy             sequencer not idle
//   o_err              pulse on unknown command or inter-byte timeout
module uart_loader_ctrl
    import uart_loader_ctrl_pkg::*;
#(
    parameter int unsigned NB_DATA = 8,
    parameter int unsigned NB_WORD = 32,
    parameter int unsigned NB_ADDR = 10,
    parameter int unsigned TIMEOUT = 1000000
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_done,
    input  logic               i_cpu_halted,
    output logic               o_imem_we,
    output logic [NB_ADDR-1:0] o_imem_addr,
    output logic [NB_WORD-1:0] o_imem_wdata,
    output logic               o_cpu_run,
    output logic               o_cpu_step,
    output logic               o_cpu_rst,
    output logic               o_busy,
    output logic               o_err
);

    localparam int unsigned BYTES_PER_WORD = NB_WORD / NB_DATA;
    localparam int unsigned NB_BIDX        = clog2_min1(BYTES_PER_WORD);
    localparam int unsigned NB_TCNT        = clog2_min1(TIMEOUT);
    localparam int unsigned ADDR_STEP      = NB_WORD / 8;

    state_t             state;
    logic [NB_DATA-1:0] word_cnt;
    logic [NB_BIDX-1:0] byte_idx;
    logic [NB_TCNT-1:0] tout_cnt;

    logic timeout_hit_c;
    logic last_byte_c;

    assign timeout_hit_c = (tout_cnt == NB_TCNT'(TIMEOUT - 1));
    assign last_byte_c   = (byte_idx == NB_BIDX'(BYTES_PER_WORD - 1));

    // Sequencer: state, datapath registers and all outputs
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= ST_IDLE;
            word_cnt     <= '0;
            byte_idx     <= '0;
            tout_cnt     <= '0;
            o_imem_we    <= 1'b0;
            o_imem_addr  <= '0;
            o_imem_wdata <= '0;
            o_cpu_run    <= 1'b0;
            o_cpu_step   <= 1'b0;
            o_cpu_rst    <= 1'b0;
            o_busy       <= 1'b0;
            o_err        <= 1'b0;
        end else begin
            o_imem_we  <= 1'b0;
            o_cpu_step <= 1'b0;
            o_cpu_rst  <= 1'b0;
            o_err      <= 1'b0;

            // Auto-stop; a command accepted this cycle overrides it below
            if (o_cpu_run && i_cpu_halted) begin
                o_cpu_run <= 1'b0;
            end

            unique case (state)
                ST_IDLE: begin
                    if (i_rx_done) begin
                        case (i_rx_data)
                            NB_DATA'(CMD_LOAD): begin
                                o_cpu_run <= 1'b0;
                                tout_cnt  <= '0;
                                state     <= ST_GET_CNT;
                                o_busy    <= 1'b1;
                            end
                            NB_DATA'(CMD_RUN): begin
                                o_cpu_run <= 1'b1;
                            end
                            NB_DATA'(CMD_STEP): begin
                                if (!o_cpu_run) begin
                                    o_cpu_step <= 1'b1;
                                end
                            end
                            NB_DATA'(CMD_HALT): begin
                                o_cpu_run <= 1'b0;
                            end
                            NB_DATA'(CMD_RESET): begin
                                o_cpu_run <= 1'b0;
                                o_cpu_rst <= 1'b1;
                            end
                            default: begin
                                o_err <= 1'b1;
                            end
                        endcase
                    end
                end

                ST_GET_CNT: begin
                    if (i_rx_done) begin
                        tout_cnt    <= '0;
                        word_cnt    <= i_rx_data;
                        byte_idx    <= '0;
                        o_imem_addr <= '0;
                        if (i_rx_data == '0) begin
                            state  <= ST_IDLE;
                            o_busy <= 1'b0;
                        end else begin
                            state <= ST_GET_WORD;
                        end
                    end else if (timeout_hit_c) begin
                        tout_cnt <= '0;
                        o_err    <= 1'b1;
                        state    <= ST_IDLE;
                        o_busy   <= 1'b0;
                    end else begin
                        tout_cnt <= tout_cnt + NB_TCNT'(1);
                    end
                end

                ST_GET_WORD: begin
                    if (i_rx_done) begin
                        tout_cnt     <= '0;
                        o_imem_wdata <= {o_imem_wdata[NB_WORD-NB_DATA-1:0], i_rx_data};
                        if (last_byte_c) begin
                            byte_idx  <= '0;
                            o_imem_we <= 1'b1;
                            state     <= ST_WRITE;
                        end else begin
                            byte_idx <= byte_idx + NB_BIDX'(1);
                        end
                    end else if (timeout_hit_c) begin
                        // Partial word is abandoned; earlier writes stand
                        tout_cnt <= '0;
                        byte_idx <= '0;
                        o_err    <= 1'b1;
                        state    <= ST_IDLE;
                        o_busy   <= 1'b0;
                    end else begin
                        tout_cnt <= tout_cnt + NB_TCNT'(1);
                    end
                end

                ST_WRITE: begin
                    // Write strobe is high this cycle; advance for the next word
                    o_imem_addr <= o_imem_addr + NB_ADDR'(ADDR_STEP);
                    word_cnt    <= word_cnt - NB_DATA'(1);
                    if (word_cnt == NB_DATA'(1)) begin
                        state  <= ST_IDLE;
                        o_busy <= 1'b0;
                    end else begin
                        state <= ST_GET_WORD;
                    end
                end

                default: begin
                    state  <= ST_IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_loader_ctrl.sv
// Self-checking bench for uart_loader_ctrl: command table, directed
// multi-cycle sequences and a randomized byte stream against a model.
module tb_uart_loader_ctrl;

    localparam int unsigned T = 50;

    typedef struct {
        logic [7:0] b;
        logic       run;
        logic       step;
        logic       rst;
        logic       err;
    } vec_t;

    typedef struct {
        logic [9:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_done;
    logic        halted;
    logic        imem_we;
    logic [9:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_run;
    logic        cpu_step;
    logic        cpu_rst;
    logic        busy;
    logic        err;

    always #5 clk = ~clk;

    uart_loader_ctrl #(
        .NB_DATA(8),
        .NB_WORD(32),
        .NB_ADDR(10),
        .TIMEOUT(T)
    ) dut (
        .clk         (clk),
        .i_rst_n     (rst_n),
        .i_rx_data   (rx_data),
        .i_rx_done   (rx_done),
        .i_cpu_halted(halted),
        .o_imem_we   (imem_we),
        .o_imem_addr (imem_addr),
        .o_imem_wdata(imem_wdata),
        .o_cpu_run   (cpu_run),
        .o_cpu_step  (cpu_step),
        .o_cpu_rst   (cpu_rst),
        .o_busy      (busy),
        .o_err       (err)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Outputs captured on the falling edge right after a byte is accepted
    logic        s_we, s_run, s_step, s_rst, s_busy, s_err;
    logic [9:0]  s_addr;
    logic [31:0] s_wdata;

    // Passive monitor of pulses and memory writes
    wr_t act_q[$];
    int  n_err_seen  = 0;
    int  n_step_seen = 0;
    int  n_rst_seen  = 0;

    always @(negedge clk) begin
        if (imem_we) act_q.push_back('{addr: imem_addr, data: imem_wdata});
        if (err) n_err_seen++;
        if (cpu_step) n_step_seen++;
        if (cpu_rst) n_rst_seen++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic sample();
        s_we = imem_we; s_addr = imem_addr; s_wdata = imem_wdata;
        s_run = cpu_run; s_step = cpu_step; s_rst = cpu_rst;
        s_busy = busy; s_err = err;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        sample();
    endtask

    function automatic logic [48:0] all_outs();
        return {imem_we, imem_addr, imem_wdata, cpu_run, cpu_step, cpu_rst, busy, err};
    endfunction

    // Reference model: byte-stream interpretation of the protocol
    int         m_mode;   // 0 idle, 1 awaiting count, 2 collecting words
    int         m_left;
    int         m_widx;
    logic [7:0] m_bytes[$];
    logic       m_run;
    int         m_err, m_step, m_rst;
    wr_t        exp_q[$];

    function automatic void model_byte(input logic [7:0] b);
        logic [31:0] w;
        if (m_mode == 0) begin
            if (b == 8'h4C) begin m_run = 1'b0; m_mode = 1; end
            else if (b == 8'h52) m_run = 1'b1;
            else if (b == 8'h53) begin if (!m_run) m_step++; end
            else if (b == 8'h48) m_run = 1'b0;
            else if (b == 8'h58) begin m_run = 1'b0; m_rst++; end
            else m_err++;
        end else if (m_mode == 1) begin
            m_left = int'(b);
            m_widx = 0;
            m_bytes.delete();
            m_mode = (b == 8'h00) ? 0 : 2;
        end else begin
            m_bytes.push_back(b);
            if (m_bytes.size() == 4) begin
                w = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
                exp_q.push_back('{addr: 10'((m_widx * 4) % 1024), data: w});
                m_widx++;
                m_left--;
                m_bytes.delete();
                if (m_left == 0) m_mode = 0;
            end
        end
    endfunction

    // Silence long enough aborts any load in progress
    function automatic void model_gap(input int g);
        if (g >= int'(T) - 1 && m_mode != 0) begin
            m_err++;
            m_mode = 0;
            m_bytes.delete();
        end
    endfunction

    task automatic r_send(input logic [7:0] b);
        send_byte(b);
        model_byte(b);
    endtask

    task automatic r_gap(input int g);
        repeat (g) @(negedge clk);
        model_gap(g);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t       tbl[11];
        logic [7:0] seq[8];
        int         base, first_err, k, n, abort_at, wr_before, err_base, step_base, rst_base;

        tbl[0]  = '{8'h53, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{8'h52, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{8'h53, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{8'h48, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{8'h52, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{8'h58, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{8'h7A, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{8'h52, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{8'h00, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{8'h48, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{8'h53, 1'b0, 1'b1, 1'b0, 1'b0};

        seq = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h01, 8'h00, 8'h04};

        rst_n = 1'b0; rx_done = 1'b0; rx_data = '0; halted = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 64'(all_outs()), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Idle command table
        for (int i = 0; i < 11; i++) begin
            send_byte(tbl[i].b);
            chk($sformatf("vec%0d.run", i), 64'(s_run), 64'(tbl[i].run));
            chk($sformatf("vec%0d.step", i), 64'(s_step), 64'(tbl[i].step));
            chk($sformatf("vec%0d.rst", i), 64'(s_rst), 64'(tbl[i].rst));
            chk($sformatf("vec%0d.err", i), 64'(s_err), 64'(tbl[i].err));
            chk($sformatf("vec%0d.we_busy", i), 64'({s_we, s_busy}), 64'(0));
            @(negedge clk);
            chk($sformatf("vec%0d.pulses_end", i), 64'({cpu_step, cpu_rst, err}), 64'(0));
        end

        // Two-word load with exact write latency
        send_byte(8'h4C);
        chk("load2.busy", 64'(s_busy), 64'(1));
        send_byte(8'h02);
        for (int i = 0; i < 8; i++) begin
            send_byte(seq[i]);
            if (i == 3) begin
                chk("load2.w0.we", 64'(s_we), 64'(1));
                chk("load2.w0.addr", 64'(s_addr), 64'(0));
                chk("load2.w0.data", 64'(s_wdata), 64'(32'h20080005));
            end else if (i == 7) begin
                chk("load2.w1.we", 64'(s_we), 64'(1));
                chk("load2.w1.addr", 64'(s_addr), 64'(4));
                chk("load2.w1.data", 64'(s_wdata), 64'(32'h8C010004));
                chk("load2.w1.busy", 64'(s_busy), 64'(1));
            end else begin
                chk($sformatf("load2.b%0d.no_we", i), 64'(s_we), 64'(0));
            end
        end
        @(negedge clk);
        chk("load2.after", 64'({imem_we, busy}), 64'(0));
        chk("load2.hold", 64'({imem_addr, imem_wdata}), 64'({10'd8, 32'h8C010004}));

        // Command values inside a load are data
        send_byte(8'h4C); send_byte(8'h01);
        send_byte(8'h52); send_byte(8'h58); send_byte(8'h53); send_byte(8'h4C);
        chk("cmd_as_data.word", 64'({s_we, s_addr, s_wdata}), 64'({1'b1, 10'd0, 32'h5258534C}));
        chk("cmd_as_data.ctrl", 64'({s_run, s_rst}), 64'(0));
        @(negedge clk);

        // Zero-length load, run and auto-stop
        wr_before = act_q.size();
        send_byte(8'h4C); send_byte(8'h00);
        chk("load0.busy", 64'(s_busy), 64'(0));
        repeat (2) @(negedge clk);
        chk("load0.no_we", 64'(act_q.size()), 64'(wr_before));
        send_byte(8'h52);
        chk("run.set", 64'(s_run), 64'(1));
        @(negedge clk);
        chk("run.held", 64'(cpu_run), 64'(1));
        halted = 1'b1;
        @(negedge clk);
        chk("run.autostop", 64'(cpu_run), 64'(0));
        send_byte(8'h52);
        chk("run.halted_set", 64'(s_run), 64'(1));
        @(negedge clk);
        chk("run.halted_clear", 64'(cpu_run), 64'(0));
        halted = 1'b0;

        // Reset mid-word, then a clean single-word load from address 0
        send_byte(8'h4C); send_byte(8'h01); send_byte(8'hAA); send_byte(8'hBB);
        chk("midword.busy", 64'(s_busy), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("midword.reset", 64'(all_outs()), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        send_byte(8'h4C); send_byte(8'h01);
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
        chk("postreset.word", 64'({s_we, s_addr, s_wdata}), 64'({1'b1, 10'd0, 32'hDEADBEEF}));

        // Reset during the write cycle drops the strobe at once
        send_byte(8'h4C); send_byte(8'h01);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        chk("midwrite.we", 64'(s_we), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("midwrite.dropped", 64'({imem_we, busy}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Inter-byte timeout boundary
        wr_before = act_q.size();
        send_byte(8'h4C); send_byte(8'h01); send_byte(8'h11); send_byte(8'h22);
        first_err = -1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (err && first_err < 0) first_err = c;
        end
        chk("timeout.cycle", 64'(first_err), 64'(50));
        chk("timeout.no_we", 64'(act_q.size()), 64'(wr_before));
        chk("timeout.idle", 64'(busy), 64'(0));
        send_byte(8'h52);
        chk("timeout.run_after", 64'(s_run), 64'(1));
        send_byte(8'h48);

        // Randomized stream against the model
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        m_mode = 0; m_left = 0; m_widx = 0; m_run = 1'b0;
        m_err = 0; m_step = 0; m_rst = 0;
        m_bytes.delete(); exp_q.delete();
        base = act_q.size();
        err_base = n_err_seen; step_base = n_step_seen; rst_base = n_rst_seen;

        for (int op = 0; op < 60; op++) begin
            if ($urandom_range(0, 9) < 5) begin
                k = int'($urandom_range(0, 4));
                case (k)
                    0: r_send(8'h52);
                    1: r_send(8'h53);
                    2: r_send(8'h48);
                    3: r_send(8'h58);
                    default: r_send(8'($urandom_range(0, 255)));
                endcase
                chk($sformatf("rand%0d.run", op), 64'(s_run), 64'(m_run));
            end else begin
                n = int'($urandom_range(0, 3));
                abort_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n * 4)) : -1;
                r_send(8'h4C);
                r_gap(int'($urandom_range(0, 4)));
                r_send(8'(n));
                for (int i = 0; i < n * 4; i++) begin
                    if (i == abort_at) begin
                        r_gap(60);
                        break;
                    end
                    r_gap(int'($urandom_range(0, 4)));
                    r_send(8'($urandom_range(0, 255)));
                end
            end
            r_gap(int'($urandom_range(0, 4)));
        end
        r_gap(60);

        chk("rand.write_count", 64'(act_q.size() - base), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < act_q.size()) begin
                chk($sformatf("rand.wr%0d", i),
                    64'({act_q[base + i].addr, act_q[base + i].data}),
                    64'({exp_q[i].addr, exp_q[i].data}));
            end
        end
        chk("rand.err_count", 64'(n_err_seen - err_base), 64'(m_err));
        chk("rand.step_count", 64'(n_step_seen - step_base), 64'(m_step));
        chk("rand.rst_count", 64'(n_rst_seen - rst_base), 64'(m_rst));
        chk("rand.run_final", 64'(cpu_run), 64'(m_run));
        chk("rand.busy_final", 64'(busy), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
